// File: rtl/tri_rasterizer.sv
// tri_rasterizer: walks a projected triangle's screen-clipped bounding box in raster order and emits covered pixels.
// Latency: 3 cycles from accept to first candidate, then one candidate per cycle; empty/degenerate triangles give tri_done 2 cycles after accept.
// Backpressure: while pix_valid && !pix_ready the output pixel and all scan state hold; ready_out is low whenever a triangle is in flight.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-low reset
//   valid_in/tri_in triangle input {y2,x2,y1,x1,y0,x0}, signed COORD_W-bit fields; accepted when ready_out is high
//   ready_out, busy idle / not-idle indication
//   pix_valid/pix_ready, hcount/vcount   covered-pixel output stream
//   tri_done        one-cycle pulse when a triangle has been fully processed
//
// Build option: define BACKFACE_CULL_EN to drop clockwise (negative-area) triangles.
module tri_rasterizer #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int COORD_W = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [6*COORD_W-1:0]   tri_in,
  output logic                   ready_out,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [8:0]             hcount,
  output logic [7:0]             vcount,
  output logic                   tri_done,
  output logic                   busy
);

  // Clipped box and scan position use one extra bit so clamping never wraps.
  localparam int CW1 = COORD_W + 1;
  localparam int EW  = 2 * COORD_W + 3;
  localparam logic signed [CW1-1:0] X_LIM  = CW1'(H_RES - 1);
  localparam logic signed [CW1-1:0] Y_LIM  = CW1'(V_RES - 1);
  localparam logic signed [CW1-1:0] C_ZERO = '0;
  localparam logic signed [CW1-1:0] C_ONE  = CW1'(1);
  localparam logic signed [EW-1:0]  E_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP0,
    S_SETUP1,
    S_SCAN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [COORD_W-1:0] vx_q [3];
  logic signed [COORD_W-1:0] vx_d [3];
  logic signed [COORD_W-1:0] vy_q [3];
  logic signed [COORD_W-1:0] vy_d [3];

  logic signed [CW1-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic signed [CW1-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic signed [CW1-1:0] cx_q, cx_d, cy_q, cy_d;

  // e_*: edge values at the current candidate; er_*: values at the start of the current row.
  logic signed [EW-1:0] e_q [3];
  logic signed [EW-1:0] e_d [3];
  logic signed [EW-1:0] er_q [3];
  logic signed [EW-1:0] er_d [3];

  logic       pix_valid_q, pix_valid_d;
  logic       last_q, last_d;   // final candidate produced a pixel still waiting to be consumed
  logic [8:0] hcount_q, hcount_d;
  logic [7:0] vcount_q, vcount_d;

  function automatic logic signed [EW-1:0] sext_v(input logic signed [COORD_W-1:0] v);
    return {{(EW-COORD_W){v[COORD_W-1]}}, v};
  endfunction

  function automatic logic signed [EW-1:0] sext_c(input logic signed [CW1-1:0] v);
    return {{(EW-CW1){v[CW1-1]}}, v};
  endfunction

  function automatic logic signed [CW1-1:0] min3(input logic signed [CW1-1:0] a,
                                                  input logic signed [CW1-1:0] b,
                                                  input logic signed [CW1-1:0] c);
    logic signed [CW1-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [CW1-1:0] max3(input logic signed [CW1-1:0] a,
                                                  input logic signed [CW1-1:0] b,
                                                  input logic signed [CW1-1:0] c);
    logic signed [CW1-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // ---------------------------------------------------------------- datapath
  logic signed [EW-1:0]  vxe [3];
  logic signed [EW-1:0]  vye [3];
  logic signed [CW1-1:0] vxc [3];
  logic signed [CW1-1:0] vyc [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      vxe[i] = sext_v(vx_q[i]);
      vye[i] = sext_v(vy_q[i]);
      vxc[i] = {vx_q[i][COORD_W-1], vx_q[i]};
      vyc[i] = {vy_q[i][COORD_W-1], vy_q[i]};
    end
  end

  // Edge i runs from vertex a to vertex b: E0 v1->v2, E1 v2->v0, E2 v0->v1.
  logic signed [EW-1:0]  xa_e [3];
  logic signed [EW-1:0]  ya_e [3];
  logic signed [EW-1:0]  dx_e [3];
  logic signed [EW-1:0]  dy_e [3];
  logic signed [EW-1:0]  e_init [3];
  logic signed [EW-1:0]  area;
  logic signed [CW1-1:0] mnx, mxx, mny, mxy;
  logic signed [CW1-1:0] bx_lo, bx_hi, by_lo, by_hi;
  logic                  box_empty;

  always_comb begin
    xa_e[0] = vxe[1];  ya_e[0] = vye[1];
    xa_e[1] = vxe[2];  ya_e[1] = vye[2];
    xa_e[2] = vxe[0];  ya_e[2] = vye[0];
    dx_e[0] = vxe[2] - vxe[1];  dy_e[0] = vye[2] - vye[1];
    dx_e[1] = vxe[0] - vxe[2];  dy_e[1] = vye[0] - vye[2];
    dx_e[2] = vxe[1] - vxe[0];  dy_e[2] = vye[1] - vye[0];

    area = (vxe[1] - vxe[0]) * (vye[2] - vye[0]) - (vye[1] - vye[0]) * (vxe[2] - vxe[0]);

    mnx = min3(vxc[0], vxc[1], vxc[2]);
    mxx = max3(vxc[0], vxc[1], vxc[2]);
    mny = min3(vyc[0], vyc[1], vyc[2]);
    mxy = max3(vyc[0], vyc[1], vyc[2]);
    bx_lo = (mnx < C_ZERO) ? C_ZERO : mnx;
    bx_hi = (mxx > X_LIM)  ? X_LIM  : mxx;
    by_lo = (mny < C_ZERO) ? C_ZERO : mny;
    by_hi = (mxy > Y_LIM)  ? Y_LIM  : mxy;
    box_empty = (bx_lo > bx_hi) || (by_lo > by_hi);

    for (int i = 0; i < 3; i++) begin
      e_init[i] = (sext_c(xmin_q) - xa_e[i]) * dy_e[i] - (sext_c(ymin_q) - ya_e[i]) * dx_e[i];
    end
  end

  logic all_ge, all_le, covered;

  always_comb begin
    all_ge = (e_q[0] >= E_ZERO) && (e_q[1] >= E_ZERO) && (e_q[2] >= E_ZERO);
    all_le = (e_q[0] <= E_ZERO) && (e_q[1] <= E_ZERO) && (e_q[2] <= E_ZERO);
`ifdef BACKFACE_CULL_EN
    // With this edge orientation, interior points of a positive-area triangle
    // see every edge value <= 0, so that is the only winding kept.
    covered = all_le;
`else
    covered = all_ge || all_le;
`endif
  end

  // --------------------------------------------------------------------- FSM
  always_comb begin
    state_d     = state_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    e_d         = e_q;
    er_d        = er_q;
    pix_valid_d = pix_valid_q;
    last_d      = last_q;
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          for (int i = 0; i < 3; i++) begin
            vx_d[i] = tri_in[2*i*COORD_W +: COORD_W];
            vy_d[i] = tri_in[(2*i+1)*COORD_W +: COORD_W];
          end
          state_d = S_SETUP0;
        end
      end

      S_SETUP0: begin
        xmin_d = bx_lo;
        xmax_d = bx_hi;
        ymin_d = by_lo;
        ymax_d = by_hi;
`ifdef BACKFACE_CULL_EN
        if (box_empty || area <= E_ZERO) state_d = S_DONE;
`else
        if (box_empty || area == E_ZERO) state_d = S_DONE;
`endif
        else state_d = S_SETUP1;
      end

      S_SETUP1: begin
        e_d     = e_init;
        er_d    = e_init;
        cx_d    = xmin_q;
        cy_d    = ymin_q;
        last_d  = 1'b0;
        state_d = S_SCAN;
      end

      S_SCAN: begin
        if (!pix_valid_q || pix_ready) begin
          if (last_q) begin
            // Final pixel has just been consumed.
            pix_valid_d = 1'b0;
            last_d      = 1'b0;
            state_d     = S_DONE;
          end else begin
            pix_valid_d = covered;
            if (covered) begin
              hcount_d = cx_q[8:0];
              vcount_d = cy_q[7:0];
            end
            if (cx_q == xmax_q && cy_q == ymax_q) begin
              if (covered) last_d  = 1'b1;
              else         state_d = S_DONE;
            end else if (cx_q != xmax_q) begin
              cx_d = cx_q + C_ONE;
              for (int i = 0; i < 3; i++) e_d[i] = e_q[i] + dy_e[i];
            end else begin
              cx_d = xmin_q;
              cy_d = cy_q + C_ONE;
              for (int i = 0; i < 3; i++) begin
                er_d[i] = er_q[i] - dx_e[i];
                e_d[i]  = er_q[i] - dx_e[i];
              end
            end
          end
        end
      end

      S_DONE: begin
        pix_valid_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      pix_valid_q <= 1'b0;
      last_q      <= 1'b0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
        e_q[i]  <= '0;
        er_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      pix_valid_q <= pix_valid_d;
      last_q      <= last_d;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= vx_d[i];
        vy_q[i] <= vy_d[i];
        e_q[i]  <= e_d[i];
        er_q[i] <= er_d[i];
      end
    end
  end

  assign ready_out = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign tri_done  = (state_q == S_DONE);
  assign pix_valid = pix_valid_q;
  assign hcount    = hcount_q;
  assign vcount    = vcount_q;

endmodule

// File: tb/tb_tri_rasterizer.sv
module tb_tri_rasterizer;
  localparam int H_RES = 320;
  localparam int V_RES = 240;
  localparam int CW    = 11;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          valid_in  = 1'b0;
  logic [6*CW-1:0] tri_in  = '0;
  logic          pix_ready = 1'b1;
  logic          ready_out, pix_valid, tri_done, busy;
  logic [8:0]    hcount;
  logic [7:0]    vcount;

  int pass_cnt = 0;
  int total    = 0;

  int exp_x[$];
  int exp_y[$];
  bit exp_empty;
  int exp_first;

  int rx0, ry0, rx1, ry1, rx2, ry2, bx, by, got, ndone, nvld;

  always #5 clk = ~clk;

  tri_rasterizer #(.H_RES(H_RES), .V_RES(V_RES), .COORD_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .tri_in    (tri_in),
    .ready_out (ready_out),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .hcount    (hcount),
    .vcount    (vcount),
    .tri_done  (tri_done),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference: direct evaluation of the three edge functions at every pixel of the clipped box.
  task automatic model(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
    int xl, xh, yl, yh, a, e0, e1, e2, k;
    bit cov;
    exp_x.delete();
    exp_y.delete();
    exp_first = -1;
    xl = imax(imin(imin(x0, x1), x2), 0);
    xh = imin(imax(imax(x0, x1), x2), H_RES - 1);
    yl = imax(imin(imin(y0, y1), y2), 0);
    yh = imin(imax(imax(y0, y1), y2), V_RES - 1);
    a  = (x1 - x0) * (y2 - y0) - (y1 - y0) * (x2 - x0);
    exp_empty = (xl > xh) || (yl > yh) || (a == 0);
`ifdef BACKFACE_CULL_EN
    if (a < 0) exp_empty = 1'b1;
`endif
    if (!exp_empty) begin
      k = 0;
      for (int y = yl; y <= yh; y++) begin
        for (int x = xl; x <= xh; x++) begin
          e0 = (x - x1) * (y2 - y1) - (y - y1) * (x2 - x1);
          e1 = (x - x2) * (y0 - y2) - (y - y2) * (x0 - x2);
          e2 = (x - x0) * (y1 - y0) - (y - y0) * (x1 - x0);
`ifdef BACKFACE_CULL_EN
          cov = (e0 <= 0) && (e1 <= 0) && (e2 <= 0);
`else
          cov = ((e0 >= 0) && (e1 >= 0) && (e2 >= 0)) || ((e0 <= 0) && (e1 <= 0) && (e2 <= 0));
`endif
          if (cov) begin
            if (exp_first < 0) exp_first = k;
            exp_x.push_back(x);
            exp_y.push_back(y);
          end
          k++;
        end
      end
    end
  endtask

  // Returns on the negedge one cycle after the accepting edge.
  task automatic send(input string name, input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
    @(negedge clk);
    valid_in = 1'b1;
    tri_in   = {CW'(y2), CW'(x2), CW'(y1), CW'(x1), CW'(y0), CW'(x0)};
    for (int i = 0; i < 100 && !ready_out; i++) @(negedge clk);
    chk({name, ":ready_before_accept"}, ready_out, 1);
    @(negedge clk);
    valid_in = 1'b0;
    chk({name, ":busy_after_accept"}, busy, 1);
    chk({name, ":ready_after_accept"}, ready_out, 0);
  endtask

  // mode 0: always ready; 1: random ready; 2: stall 5 cycles on pixel (1,1)
  task automatic run_tri(input string name, input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input int mode);
    int idx, cyc, done_cyc, first_vld, stalls;
    idx = 0; cyc = 1; done_cyc = -1; first_vld = -1; stalls = 0;
    model(x0, y0, x1, y1, x2, y2);
    send(name, x0, y0, x1, y1, x2, y2);
    while (done_cyc < 0 && cyc < 20000) begin
      if (tri_done) begin
        done_cyc = cyc;
      end else begin
        case (mode)
          1: pix_ready = ($urandom_range(0, 3) != 0);
          2: begin
            if (pix_valid && hcount == 9'd1 && vcount == 8'd1 && stalls < 5) begin
              pix_ready = 1'b0;
              stalls++;
            end else begin
              pix_ready = 1'b1;
            end
          end
          default: pix_ready = 1'b1;
        endcase
        if (pix_valid) begin
          if (first_vld < 0) first_vld = cyc;
          if (idx < exp_x.size()) begin
            chk({name, ":hcount"}, hcount, exp_x[idx]);
            chk({name, ":vcount"}, vcount, exp_y[idx]);
          end else begin
            chk({name, ":extra_pixel"}, pix_valid, 0);
          end
          if (pix_ready) idx++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    pix_ready = 1'b1;
    chk({name, ":done_seen"}, (done_cyc >= 0), 1);
    chk({name, ":pixel_count"}, idx, exp_x.size());
    chk({name, ":valid_at_done"}, pix_valid, 0);
    if (exp_empty) chk({name, ":done_latency"}, done_cyc, 2);
    else if (exp_first >= 0) chk({name, ":first_pixel_latency"}, first_vld, 4 + exp_first);
    if (mode == 2) chk({name, ":stall_cycles"}, stalls, 5);
    @(negedge clk);
    chk({name, ":done_one_cycle"}, tri_done, 0);
    chk({name, ":ready_after_done"}, ready_out, 1);
    chk({name, ":idle_after_done"}, busy, 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #3;
    chk("reset:ready_out", ready_out, 1);
    chk("reset:pix_valid", pix_valid, 0);
    chk("reset:hcount", hcount, 0);
    chk("reset:vcount", vcount, 0);
    chk("reset:tri_done", tri_done, 0);
    chk("reset:busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_tri("basic", 0, 0, 3, 0, 0, 3, 0);
    run_tri("degenerate", 0, 0, 5, 5, 10, 10, 0);
    run_tri("offscreen", -20, -20, -10, -20, -20, -10, 0);
    run_tri("stall11", 0, 0, 3, 0, 0, 3, 2);

    // Reset in the middle of a scan.
    send("rst_mid", 0, 0, 3, 0, 0, 3);
    pix_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got < 3; i++) begin
      if (pix_valid) got++;
      @(negedge clk);
    end
    chk("rst_mid:pixels_before_reset", got, 3);
    rst = 1'b0;
    #1;
    chk("rst_mid:pix_valid", pix_valid, 0);
    chk("rst_mid:busy", busy, 0);
    chk("rst_mid:ready_out", ready_out, 1);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    nvld  = 0;
    for (int i = 0; i < 20; i++) begin
      if (tri_done) ndone++;
      if (pix_valid) nvld++;
      @(negedge clk);
    end
    chk("rst_mid:no_tri_done", ndone, 0);
    chk("rst_mid:no_pixels", nvld, 0);
    run_tri("after_reset", 0, 0, 3, 0, 0, 3, 0);

    run_tri("clockwise", 0, 0, 0, 3, 3, 0, 0);
    run_tri("right_clip", 315, 100, 330, 104, 316, 110, 0);
    run_tri("bottom_clip", 20, 236, 28, 245, 12, 250, 0);

    for (int t = 0; t < 16; t++) begin
      bx = ((t % 4) == 3) ? 300 : -6;
      by = ((t % 4) == 3) ? 222 : -6;
      rx0 = bx + int'($urandom_range(0, 28));
      ry0 = by + int'($urandom_range(0, 28));
      rx1 = bx + int'($urandom_range(0, 28));
      ry1 = by + int'($urandom_range(0, 28));
      rx2 = bx + int'($urandom_range(0, 28));
      ry2 = by + int'($urandom_range(0, 28));
      run_tri("random", rx0, ry0, rx1, ry1, rx2, ry2, 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
